// File: rtl/multi_servo_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// multi_servo_ramp_ctrl
//
// Drives NUM_CH hobby servos from one shared PWM frame counter. Each channel
// takes CW/CCW step commands and a low-active sensor override that parks the
// servo at MAX_PULSE for HOLD_CYC cycles before it returns to centre.
// The applied pulse width (cur) follows the target once per frame.
//
// Build option:
//   SERVO_RAMP_EN defined   : cur moves at most RAMP_CYC per frame (slew limit).
//   SERVO_RAMP_EN undefined : cur snaps to target at every frame boundary.
// -----------------------------------------------------------------------------
module multi_servo_ramp_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int PERIOD_CYC = 1_000_000,
  parameter int MIN_PULSE  = 25_000,
  parameter int MAX_PULSE  = 125_000,
  parameter int STEP_CYC   = 50_000,
  parameter int RAMP_CYC   = 2_500,
  parameter int HOLD_CYC   = 200_000_000,
  parameter int DEB_CYC    = 1_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sensor_n,
  input  logic [NUM_CH-1:0] cw_cmd,
  input  logic [NUM_CH-1:0] ccw_cmd,
  output logic [NUM_CH-1:0] servo_pwm,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] override,
  output logic              frame_start
);

  // Widths: pulse registers, one extra bit for sums, frame/hold/debounce counters.
  localparam int PW   = $clog2(MAX_PULSE + 1);
  localparam int PX   = PW + 1;
  localparam int FW   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int CMPW = (PW > FW) ? PW : FW;
  localparam int HW   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int DW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

`ifdef SERVO_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  // Without slew limiting the per-frame limit covers the whole travel range,
  // so the same ramp datapath degenerates into cur <= target.
  localparam int SLEW_LIM = RAMP_EN ? RAMP_CYC : MAX_PULSE;

  localparam logic [FW-1:0] FRAME_LAST = FW'(PERIOD_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYC - 1);

  localparam logic [PW-1:0] MIN_P    = PW'(MIN_PULSE);
  localparam logic [PW-1:0] MAX_P    = PW'(MAX_PULSE);
  localparam logic [PW-1:0] CENTER_P = PW'((MIN_PULSE + MAX_PULSE) / 2);

  localparam logic [PX-1:0] MAX_X   = PX'(MAX_PULSE);
  localparam logic [PX-1:0] STEP_X  = PX'(STEP_CYC);
  localparam logic [PX-1:0] FLOOR_X = PX'(MIN_PULSE + STEP_CYC);
  localparam logic [PX-1:0] SLEW_X  = PX'(SLEW_LIM);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } ch_state_e;

  // ---------------------------------------------------------------------------
  // Shared frame counter
  // ---------------------------------------------------------------------------
  logic [FW-1:0] frame_q;
  logic [FW-1:0] frame_d;
  logic          frame_last;
  logic          frame_start_q;

  assign frame_last = (frame_q == FRAME_LAST);
  assign frame_d    = frame_last ? '0 : frame_q + 1'b1;

  // Frame counter and the registered frame-start marker.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_q       <= frame_d;
      frame_start_q <= (frame_q == '0);
    end
  end

  assign frame_start = frame_start_q;

  // ---------------------------------------------------------------------------
  // Per-channel logic
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic [DW-1:0]   deb_cnt_q;
    ch_state_e       state_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [PW-1:0]   tgt_q;
    logic [PW-1:0]   tgt_cmd_d;
    logic [PW-1:0]   cur_q;
    logic [PW-1:0]   cur_d;
    logic [PX-1:0]   tgt_x;
    logic [PX-1:0]   cur_x;
    logic [PX-1:0]   up_x;
    logic [PX-1:0]   diff_x;
    logic            ovr_q;
    logic            pwm_q;
    logic            busy_q;

    assign tgt_x = {1'b0, tgt_q};
    assign cur_x = {1'b0, cur_q};
    assign up_x  = tgt_x + STEP_X;

    // Two-flop synchroniser for the asynchronous sensor input (idle high).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= sensor_n[i];
        sync2_q <= sync1_q;
      end
    end

    // Debounce: adopt the synchronised level only after it has differed from
    // the stable value for DEB_CYC consecutive cycles; any agreement restarts.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stable_q  <= 1'b1;
        deb_cnt_q <= '0;
      end else if (sync2_q == stable_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        stable_q  <= sync2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end

    // Command target: saturating step up/down, conflicting commands ignored.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
      tgt_cmd_d = tgt_q;
      if (cw_cmd[i] && !ccw_cmd[i]) begin
        tgt_cmd_d = (up_x > MAX_X) ? MAX_P : up_x[PW-1:0];
      end else if (ccw_cmd[i] && !cw_cmd[i]) begin
        tgt_cmd_d = (tgt_x < FLOOR_X) ? MIN_P : PW'(tgt_x - STEP_X);
      end
    end

    // Sensor override FSM: a trigger parks the target at MAX_PULSE for
    // HOLD_CYC cycles; commands are honoured only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= ST_IDLE;
        tgt_q      <= CENTER_P;
        hold_cnt_q <= '0;
        ovr_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!stable_q) begin
              state_q    <= ST_HOLD;
              tgt_q      <= MAX_P;
              hold_cnt_q <= '0;
              ovr_q      <= 1'b1;
            end else begin
              tgt_q <= tgt_cmd_d;
            end
          end
          ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_q <= ST_IDLE;
              tgt_q   <= CENTER_P;
              ovr_q   <= 1'b0;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            ovr_q   <= 1'b0;
          end
        endcase
      end
    end

    // Next applied pulse width: move toward target by at most SLEW_LIM.
    always_comb begin
      cur_d  = cur_q;
      diff_x = '0;
      if (tgt_x > cur_x) begin
        diff_x = tgt_x - cur_x;
        cur_d  = (diff_x > SLEW_X) ? PW'(cur_x + SLEW_X) : tgt_q;
      end else if (cur_x > tgt_x) begin
        diff_x = cur_x - tgt_x;
        cur_d  = (diff_x > SLEW_X) ? PW'(cur_x - SLEW_X) : tgt_q;
      end
    end

    // Applied width changes only on the last frame cycle, so every pulse
    // starts and ends with one consistent width (glitch-free).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cur_q <= CENTER_P;
      end else if (frame_last) begin
        cur_q <= cur_d;
      end
    end

    // Registered PWM compare and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pwm_q  <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        pwm_q  <= (CMPW'(frame_q) < CMPW'(cur_q));
        busy_q <= (cur_q != tgt_q);
      end
    end

    assign servo_pwm[i] = pwm_q;
    assign busy[i]      = busy_q;
    assign override[i]  = ovr_q;
  end

endmodule

// File: tb/tb_multi_servo_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for multi_servo_ramp_ctrl with small parameters.
// Expected per-frame pulse widths are queued when stimulus is applied and
// popped when the following measured frame completes. Expectations depend on
// whether SERVO_RAMP_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_multi_servo_ramp_ctrl;

  localparam int NUM_CH = 4;
  localparam int PERIOD = 1000;
  localparam int MIN_P  = 25;
  localparam int MAX_P  = 125;
  localparam int STEP   = 50;
  localparam int RAMP   = 10;
  localparam int HOLD   = 5000;
  localparam int DEB    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] sensor_n = '1;
  logic [NUM_CH-1:0] cw_cmd = '0;
  logic [NUM_CH-1:0] ccw_cmd = '0;
  logic [NUM_CH-1:0] servo_pwm;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] override;
  logic              frame_start;

  multi_servo_ramp_ctrl #(
    .NUM_CH    (NUM_CH),
    .PERIOD_CYC(PERIOD),
    .MIN_PULSE (MIN_P),
    .MAX_PULSE (MAX_P),
    .STEP_CYC  (STEP),
    .RAMP_CYC  (RAMP),
    .HOLD_CYC  (HOLD),
    .DEB_CYC   (DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_n   (sensor_n),
    .cw_cmd     (cw_cmd),
    .ccw_cmd    (ccw_cmd),
    .servo_pwm  (servo_pwm),
    .busy       (busy),
    .override   (override),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int failed    = 0;

  typedef struct {
    string tag;
    int    ch;
    int    val;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance to the next negedge where frame_start is high (bounded).
  task automatic wait_frame_start();
    for (int k = 0; k < 2 * PERIOD + 4; k++) begin
      @(negedge clk);
      if (frame_start === 1'b1) return;
    end
    check("frame_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_widths(input string tag, input int w0, input int w1, input int w2, input int w3);
    int w [NUM_CH];
    w = '{w0, w1, w2, w3};
    for (int c = 0; c < NUM_CH; c++) begin
      exp_t e;
      e.tag = $sformatf("%s_ch%0d", tag, c);
      e.ch  = c;
      e.val = w[c];
      exp_q.push_back(e);
    end
  endtask

  // Measure the high time of every channel over the next full frame, then
  // score all queued expectations against it.
  task automatic measure_and_score();
    int w [NUM_CH];
    exp_t e;
    wait_frame_start();
    foreach (w[c]) w[c] = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k != 0) @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) w[c] += int'(servo_pwm[c]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, w[e.ch], e.val);
    end
  endtask

  // One-cycle command pulse, applied from a negedge.
  task automatic pulse(input logic [NUM_CH-1:0] cw_m, input logic [NUM_CH-1:0] ccw_m);
    cw_cmd  = cw_m;
    ccw_cmd = ccw_m;
    @(negedge clk);
    cw_cmd  = '0;
    ccw_cmd = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, rise_cyc, fall_cyc;
    int seq_cw0 [6];
    int busy_cw0 [6];
`ifdef SERVO_RAMP_EN
    seq_cw0  = '{85, 95, 105, 115, 125, 125};
    busy_cw0 = '{1, 1, 1, 1, 0, 0};
`else
    seq_cw0  = '{125, 125, 125, 125, 125, 125};
    busy_cw0 = '{0, 0, 0, 0, 0, 0};
`endif

    // ---- reset state and release ----
    repeat (3) @(negedge clk);
    check("rst_pwm", servo_pwm, 4'h0);
    check("rst_busy", busy, 4'h0);
    check("rst_override", override, 4'h0);
    check("rst_frame_start", frame_start, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_frame_start", frame_start, 1'b1);
    check("first_pwm", servo_pwm, 4'hF);
    c0 = cyc;
    @(negedge clk);
    check("frame_start_width", frame_start, 1'b0);
    wait_frame_start();
    check("frame_period", cyc - c0, PERIOD);
    push_widths("reset", 75, 75, 75, 75);
    measure_and_score();
    check("reset_busy_idle", busy, 4'h0);

    // ---- cw on channel 0 ----
    wait_frame_start();
    repeat (500) @(negedge clk);
    pulse(4'b0001, 4'b0000);
    @(negedge clk);
    check("cw0_busy_rise", busy, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      push_widths($sformatf("cw0_f%0d", k), seq_cw0[k], 75, 75, 75);
      measure_and_score();
      check($sformatf("cw0_busy_f%0d", k), busy[0], busy_cw0[k]);
    end

    // ---- channel 1 clamps ----
    wait_frame_start();
    repeat (400) @(negedge clk);
    pulse(4'b0010, 4'b0000);
    pulse(4'b0010, 4'b0000);
    pulse(4'b0010, 4'b0000);
    repeat (4) wait_frame_start();
    push_widths("cw1_clamp", 125, 125, 75, 75);
    measure_and_score();

    wait_frame_start();
    repeat (400) @(negedge clk);
    pulse(4'b0000, 4'b0010);
    pulse(4'b0000, 4'b0010);
    pulse(4'b0000, 4'b0010);
    repeat (9) wait_frame_start();
    push_widths("ccw1_clamp", 125, 25, 75, 75);
    measure_and_score();

    wait_frame_start();
    repeat (400) @(negedge clk);
    pulse(4'b0010, 4'b0010);
    push_widths("both1", 125, 25, 75, 75);
    measure_and_score();
    check("both1_busy", busy, 4'h0);

    // ---- channel 2 sensor hold ----
    wait_frame_start();
    repeat (100) @(negedge clk);
    sensor_n[2] = 1'b0;
    repeat (10) @(negedge clk);
    check("ovr_pre_rise", override, 4'b0000);
    @(negedge clk);
    check("ovr_rise", override, 4'b0100);
    rise_cyc = cyc;
    pulse(4'b0000, 4'b0100);
    repeat (8) @(negedge clk);
    sensor_n[2] = 1'b1;
`ifdef SERVO_RAMP_EN
    push_widths("hold_f1", 125, 25, 85, 75);
`else
    push_widths("hold_f1", 125, 25, 125, 75);
`endif
    measure_and_score();
    check("ovr_holding", override, 4'b0100);
    fall_cyc = cyc;
    for (int k = 0; k < HOLD + PERIOD; k++) begin
      @(negedge clk);
      fall_cyc = cyc;
      if (override[2] === 1'b0) break;
    end
    check("hold_len", fall_cyc - rise_cyc, HOLD);
`ifdef SERVO_RAMP_EN
    push_widths("hold_exit", 125, 25, 115, 75);
`else
    push_widths("hold_exit", 125, 25, 75, 75);
`endif
    measure_and_score();
    check("ovr_after_hold", override, 4'b0000);

    // ---- channel 3 sensor glitch ----
    sensor_n[3] = 1'b0;
    repeat (5) @(negedge clk);
    sensor_n[3] = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_ovr", override, 4'b0000);
    repeat (3) wait_frame_start();
    push_widths("glitch", 125, 25, 75, 75);
    measure_and_score();

    // ---- asynchronous reset mid-ramp ----
    wait_frame_start();
    repeat (300) @(negedge clk);
    pulse(4'b0000, 4'b0001);
    wait_frame_start();
    repeat (10) @(negedge clk);
    check("pre_reset_pwm", servo_pwm, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", servo_pwm, 4'h0);
    check("async_rst_busy", busy, 4'h0);
    check("async_rst_ovr_fs", {override, frame_start}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    push_widths("post_reset", 75, 75, 75, 75);
    measure_and_score();
    check("post_reset_busy", busy, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
